// File: rtl/serdes_rst_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serdes_rst_pkg
// Brief    : State encoding, count widths and lane-walk helper for the
//            SerDes reset sequencer.
// Revision : 1.0
// ============================================================================
package serdes_rst_pkg;

    localparam int STATE_W    = 3;
    localparam int LOST_CNT_W = 8;
    localparam int MAX_LANES  = 32;
    localparam int LANE_IDX_W = 5;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOCK_WAIT = 3'd1;
    localparam logic [STATE_W-1:0] ST_STOP_S    = 3'd2;
    localparam logic [STATE_W-1:0] ST_RST_S     = 3'd3;
    localparam logic [STATE_W-1:0] ST_RST_E     = 3'd4;
    localparam logic [STATE_W-1:0] ST_REL       = 3'd5;
    localparam logic [STATE_W-1:0] ST_STOP_E    = 3'd6;
    localparam logic [STATE_W-1:0] ST_READY     = 3'd7;

    // Lowest set bit of the still-in-reset vector; 0 when nothing is pending.
    function automatic logic [LANE_IDX_W-1:0] next_lane(input logic [MAX_LANES-1:0] pending);
        logic [LANE_IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_LANES - 1; i >= 0; i--) begin
            if (pending[i]) begin
                idx = LANE_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serdes_rst_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : serdes_rst_seq_if
// Brief    : Lock/mask/restart inputs and reset/status outputs of the sequencer.
// Revision : 1.0
// ============================================================================
interface serdes_rst_seq_if #(
    parameter int NUM_LANES = 4
) ();

    logic                                   I_pll_lock;
    logic [NUM_LANES-1:0]                   I_lane_en;
    logic                                   I_restart;
    logic                                   O_clk_stop;
    logic [NUM_LANES-1:0]                   O_serdes_rst;
    logic                                   O_ready;
    logic [serdes_rst_pkg::STATE_W-1:0]     O_state;
    logic [serdes_rst_pkg::LOST_CNT_W-1:0]  O_lock_lost_cnt;

    modport master (
        output I_pll_lock,
        output I_lane_en,
        output I_restart,
        input  O_clk_stop,
        input  O_serdes_rst,
        input  O_ready,
        input  O_state,
        input  O_lock_lost_cnt
    );

    modport slave (
        input  I_pll_lock,
        input  I_lane_en,
        input  I_restart,
        output O_clk_stop,
        output O_serdes_rst,
        output O_ready,
        output O_state,
        output O_lock_lost_cnt
    );

endinterface
`default_nettype wire

// File: rtl/serdes_lock_filter.sv
`default_nettype none
// ============================================================================
// Module   : serdes_lock_filter
// Brief    : Flags PLL lock as stable after T_LOCK_STABLE consecutive high samples.
// Revision : 1.0
// ============================================================================
module serdes_lock_filter #(
    parameter int CNT_W         = 10,
    parameter int T_LOCK_STABLE = 64
) (
    input  wire logic I_clk,
    input  wire logic I_rst,
    input  wire logic I_lock,
    output logic      O_lock_stable
);

    localparam logic [CNT_W-1:0] C_LOCK_LAST = CNT_W'(T_LOCK_STABLE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;

    // Count saturates at the threshold so a long lock keeps the flag asserted.
    always_comb begin
        cnt_d    = '0;
        stable_d = 1'b0;
        if (I_lock) begin
            cnt_d    = (cnt_q == C_LOCK_LAST) ? cnt_q : cnt_q + CNT_W'(1);
            stable_d = (cnt_q == C_LOCK_LAST);
        end
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign O_lock_stable = stable_q;

endmodule
`default_nettype wire

// File: rtl/serdes_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : serdes_rst_seq
// Brief    : Multi-lane SerDes reset sequencer: lock debounce, clock stop,
//            lane reset, staggered release, clock restart, lock-loss count.
// Revision : 1.0
// ============================================================================
module serdes_rst_seq
    import serdes_rst_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int CNT_W         = 10,
    parameter int T_LOCK_STABLE = 64,
    parameter int T_STOP_PRE    = 64,
    parameter int T_RST_PRE     = 32,
    parameter int T_RST         = 8,
    parameter int T_LANE_GAP    = 0,
    parameter int T_STOP_POST   = 128
) (
    input  wire logic        I_clk,
    input  wire logic        I_rst,
    serdes_rst_seq_if.slave  bus
);

    localparam int                C_CNT_LIM       = 1 << CNT_W;
    localparam logic [CNT_W-1:0] C_STOP_PRE_LAST  = CNT_W'(T_STOP_PRE - 1);
    localparam logic [CNT_W-1:0] C_RST_PRE_LAST   = CNT_W'(T_RST_PRE - 1);
    localparam logic [CNT_W-1:0] C_RST_LAST       = CNT_W'(T_RST - 1);
    localparam logic [CNT_W-1:0] C_STOP_POST_LAST = CNT_W'(T_STOP_POST - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST       = (T_LANE_GAP == 0) ? '0 : CNT_W'(T_LANE_GAP - 1);

    if (NUM_LANES < 1 || NUM_LANES > MAX_LANES) begin : g_chk_lanes
        $error("serdes_rst_seq: NUM_LANES out of range");
    end
    if (T_LOCK_STABLE < 1 || T_LOCK_STABLE >= C_CNT_LIM) begin : g_chk_lock
        $error("serdes_rst_seq: T_LOCK_STABLE out of range");
    end
    if (T_STOP_PRE < 1 || T_STOP_PRE >= C_CNT_LIM) begin : g_chk_stop_pre
        $error("serdes_rst_seq: T_STOP_PRE out of range");
    end
    if (T_RST_PRE < 1 || T_RST_PRE >= C_CNT_LIM) begin : g_chk_rst_pre
        $error("serdes_rst_seq: T_RST_PRE out of range");
    end
    if (T_RST < 1 || T_RST >= C_CNT_LIM) begin : g_chk_rst
        $error("serdes_rst_seq: T_RST out of range");
    end
    if (T_LANE_GAP < 0 || T_LANE_GAP >= C_CNT_LIM) begin : g_chk_gap
        $error("serdes_rst_seq: T_LANE_GAP out of range");
    end
    if (T_STOP_POST < 1 || T_STOP_POST >= C_CNT_LIM) begin : g_chk_stop_post
        $error("serdes_rst_seq: T_STOP_POST out of range");
    end

    logic [STATE_W-1:0]    state_q,      state_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic [NUM_LANES-1:0]  mask_q,       mask_d;
    logic                  clk_stop_q,   clk_stop_d;
    logic [NUM_LANES-1:0]  serdes_rst_q, serdes_rst_d;
    logic                  ready_q,      ready_d;
    logic [LOST_CNT_W-1:0] lost_cnt_q,   lost_cnt_d;

    logic                  w_lock_stable;
    logic                  w_in_seq;
    logic [LANE_IDX_W-1:0] w_lane_idx;
    logic [NUM_LANES-1:0]  w_rel_vec;

    serdes_lock_filter #(
        .CNT_W         (CNT_W),
        .T_LOCK_STABLE (T_LOCK_STABLE)
    ) u_lock_filter (
        .I_clk         (I_clk),
        .I_rst         (I_rst),
        .I_lock        (bus.I_pll_lock),
        .O_lock_stable (w_lock_stable)
    );

    assign w_in_seq   = (state_q != ST_IDLE) && (state_q != ST_LOCK_WAIT);
    // Lanes still held in reset are exactly the pending releases.
    assign w_lane_idx = next_lane(MAX_LANES'(serdes_rst_q));
    assign w_rel_vec  = serdes_rst_q & ~(NUM_LANES'(1) << w_lane_idx);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        mask_d       = mask_q;
        clk_stop_d   = clk_stop_q;
        serdes_rst_d = serdes_rst_q;
        lost_cnt_d   = lost_cnt_q;

        if (w_in_seq && !bus.I_pll_lock) begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            clk_stop_d   = 1'b0;
            serdes_rst_d = '0;
            if (lost_cnt_q != '1) begin
                lost_cnt_d = lost_cnt_q + LOST_CNT_W'(1);
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d        = '0;
                    clk_stop_d   = 1'b0;
                    serdes_rst_d = '0;
                    if (bus.I_pll_lock) begin
                        state_d = ST_LOCK_WAIT;
                    end
                end
                ST_LOCK_WAIT: begin
                    cnt_d = '0;
                    if (w_lock_stable && bus.I_pll_lock) begin
                        state_d = ST_STOP_S;
                        mask_d  = bus.I_lane_en;
                    end
                end
                ST_STOP_S: begin
                    if (cnt_q == C_STOP_PRE_LAST) begin
                        state_d    = ST_RST_S;
                        cnt_d      = '0;
                        clk_stop_d = 1'b1;
                    end
                end
                ST_RST_S: begin
                    if (cnt_q == C_RST_PRE_LAST) begin
                        state_d      = ST_RST_E;
                        cnt_d        = '0;
                        serdes_rst_d = mask_q;
                    end
                end
                ST_RST_E: begin
                    if (cnt_q == C_RST_LAST) begin
                        state_d = ST_REL;
                        cnt_d   = '0;
                    end
                end
                ST_REL: begin
                    // Counter runs modulo the gap; a release happens each time it wraps to 0.
                    cnt_d = (cnt_q == C_GAP_LAST) ? '0 : cnt_q + CNT_W'(1);
                    if (T_LANE_GAP == 0) begin
                        serdes_rst_d = '0;
                        state_d      = ST_STOP_E;
                        cnt_d        = '0;
                    end else if (cnt_q == '0) begin
                        serdes_rst_d = w_rel_vec;
                        if (w_rel_vec == '0) begin
                            state_d = ST_STOP_E;
                            cnt_d   = '0;
                        end
                    end
                end
                ST_STOP_E: begin
                    if (cnt_q == C_STOP_POST_LAST) begin
                        state_d    = ST_READY;
                        cnt_d      = '0;
                        clk_stop_d = 1'b0;
                    end
                end
                ST_READY: begin
                    cnt_d = '0;
                    if (bus.I_restart) begin
                        state_d = ST_STOP_S;
                        mask_d  = bus.I_lane_en;
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    cnt_d        = '0;
                    clk_stop_d   = 1'b0;
                    serdes_rst_d = '0;
                end
            endcase
        end

        ready_d = (state_d == ST_READY);
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mask_q       <= '0;
            clk_stop_q   <= 1'b0;
            serdes_rst_q <= '0;
            ready_q      <= 1'b0;
            lost_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            clk_stop_q   <= clk_stop_d;
            serdes_rst_q <= serdes_rst_d;
            ready_q      <= ready_d;
            lost_cnt_q   <= lost_cnt_d;
        end
    end

    assign bus.O_clk_stop      = clk_stop_q;
    assign bus.O_serdes_rst    = serdes_rst_q;
    assign bus.O_ready         = ready_q;
    assign bus.O_state         = state_q;
    assign bus.O_lock_lost_cnt = lost_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_serdes_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_serdes_rst_seq
// Brief    : Scoreboard bench: one sequencer with default timing, one with
//            short timing and a lane gap of 3.
// Revision : 1.0
// ============================================================================
module tb_serdes_rst_seq;
    import serdes_rst_pkg::*;

    localparam int A_TL = 64, A_SP = 64, A_RP = 32, A_R = 8, A_G = 0, A_SPOST = 128;
    localparam int B_TL = 4,  B_SP = 3,  B_RP = 2,  B_R = 2, B_G = 3, B_SPOST = 5;
    localparam int BIG  = 32'h7fff_ffff;

    typedef struct {
        int          cyc;
        logic [16:0] snap;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic mon_en  = 1'b0;

    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        ea, eb;
    logic [16:0] sa, sb, prev_a, prev_b;

    serdes_rst_seq_if #(.NUM_LANES(4)) bus_a ();
    serdes_rst_seq_if #(.NUM_LANES(4)) bus_b ();

    serdes_rst_seq #(
        .NUM_LANES(4), .CNT_W(10), .T_LOCK_STABLE(A_TL), .T_STOP_PRE(A_SP),
        .T_RST_PRE(A_RP), .T_RST(A_R), .T_LANE_GAP(A_G), .T_STOP_POST(A_SPOST)
    ) u_dut_a (
        .I_clk (clk),
        .I_rst (rst_a),
        .bus   (bus_a)
    );

    serdes_rst_seq #(
        .NUM_LANES(4), .CNT_W(10), .T_LOCK_STABLE(B_TL), .T_STOP_PRE(B_SP),
        .T_RST_PRE(B_RP), .T_RST(B_R), .T_LANE_GAP(B_G), .T_STOP_POST(B_SPOST)
    ) u_dut_b (
        .I_clk (clk),
        .I_rst (rst_b),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic pe(input int sel, input int t, input int lim, input logic [2:0] st,
                      input logic cs, input logic [3:0] rs, input logic rdy, input logic [7:0] lc);
        exp_t e;
        if (t < lim) begin
            e.cyc  = t;
            e.snap = {st, cs, rs, rdy, lc};
            if (sel == 0) qa.push_back(e);
            else          qb.push_back(e);
        end
    endtask

    // Expected output changes of one uninterrupted sequence starting with STOP_S entry at e0.
    task automatic seq_exp(input int sel, input int e0, input logic [3:0] mask, input logic [7:0] lc,
                           input int lim, output int t_ready);
        int         sp, rp, r, g, spost, t;
        logic [3:0] cur;
        bit         first;
        if (sel == 0) begin sp = A_SP; rp = A_RP; r = A_R; g = A_G; spost = A_SPOST; end
        else          begin sp = B_SP; rp = B_RP; r = B_R; g = B_G; spost = B_SPOST; end
        t = e0;      pe(sel, t, lim, ST_STOP_S, 1'b0, 4'h0, 1'b0, lc);
        t = t + sp;  pe(sel, t, lim, ST_RST_S,  1'b1, 4'h0, 1'b0, lc);
        t = t + rp;  pe(sel, t, lim, ST_RST_E,  1'b1, mask, 1'b0, lc);
        t = t + r;   pe(sel, t, lim, ST_REL,    1'b1, mask, 1'b0, lc);
        if (g == 0 || mask == 4'h0) begin
            t = t + 1; pe(sel, t, lim, ST_STOP_E, 1'b1, 4'h0, 1'b0, lc);
        end else begin
            cur   = mask;
            first = 1'b1;
            t     = t + 1;
            for (int i = 0; i < 4; i++) begin
                if (cur[i]) begin
                    if (!first) t = t + g;
                    first  = 1'b0;
                    cur[i] = 1'b0;
                    pe(sel, t, lim, (cur == 4'h0) ? ST_STOP_E : ST_REL, 1'b1, cur, 1'b0, lc);
                end
            end
        end
        t = t + spost; pe(sel, t, lim, ST_READY, 1'b0, 4'h0, 1'b1, lc);
        t_ready = t;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            sa = {bus_a.O_state, bus_a.O_clk_stop, bus_a.O_serdes_rst, bus_a.O_ready, bus_a.O_lock_lost_cnt};
            if (sa !== prev_a) begin
                if (qa.size() == 0) begin
                    check("A_unexpected_change", 32'(sa), 32'(prev_a));
                end else begin
                    ea = qa.pop_front();
                    check("A_cycle", 32'(cyc), 32'(ea.cyc));
                    check("A_outputs", 32'(sa), 32'(ea.snap));
                end
                prev_a = sa;
            end
            sb = {bus_b.O_state, bus_b.O_clk_stop, bus_b.O_serdes_rst, bus_b.O_ready, bus_b.O_lock_lost_cnt};
            if (sb !== prev_b) begin
                if (qb.size() == 0) begin
                    check("B_unexpected_change", 32'(sb), 32'(prev_b));
                end else begin
                    eb = qb.pop_front();
                    check("B_cycle", 32'(cyc), 32'(eb.cyc));
                    check("B_outputs", 32'(sb), 32'(eb.snap));
                end
                prev_b = sb;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         x, e0, tr;
        logic [7:0] lcb;

        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.I_pll_lock = 1'b0; bus_a.I_lane_en = 4'h0; bus_a.I_restart = 1'b0;
        bus_b.I_pll_lock = 1'b0; bus_b.I_lane_en = 4'h0; bus_b.I_restart = 1'b0;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        check("A_rst_state",    32'(bus_a.O_state),         32'd0);
        check("A_rst_clk_stop", 32'(bus_a.O_clk_stop),      32'd0);
        check("A_rst_lanes",    32'(bus_a.O_serdes_rst),    32'd0);
        check("A_rst_ready",    32'(bus_a.O_ready),         32'd0);
        check("A_rst_lost",     32'(bus_a.O_lock_lost_cnt), 32'd0);
        check("B_rst_state",    32'(bus_b.O_state),         32'd0);
        prev_a = '0; prev_b = '0;
        mon_en = 1'b1;

        // Full default sequence, all lanes.
        @(negedge clk);
        x = cyc; bus_a.I_lane_en = 4'hF; bus_a.I_pll_lock = 1'b1;
        pe(0, x + 1, BIG, ST_LOCK_WAIT, 1'b0, 4'h0, 1'b0, 8'd0);
        e0 = x + A_TL + 1;
        seq_exp(0, e0, 4'hF, 8'd0, BIG, tr);
        wait_until(tr + 2);
        check("A_ready", 32'(bus_a.O_ready), 32'd1);
        check("A_state_ready", 32'(bus_a.O_state), 32'd7);

        // Restart with only lane 1; a restart and mask change inside RST_S are ignored.
        x = cyc; bus_a.I_restart = 1'b1; bus_a.I_lane_en = 4'h2;
        @(negedge clk); bus_a.I_restart = 1'b0;
        e0 = x + 1;
        seq_exp(0, e0, 4'h2, 8'd0, BIG, tr);
        wait_until(e0 + A_SP + 5);
        bus_a.I_restart = 1'b1; bus_a.I_lane_en = 4'hF;
        @(negedge clk); bus_a.I_restart = 1'b0;
        wait_until(e0 + A_SP + A_RP + 2);
        check("A_restart_lane1", 32'(bus_a.O_serdes_rst), 32'h2);
        wait_until(tr + 2);

        // Restart with all lanes, then lose lock inside RST_E.
        x = cyc; bus_a.I_restart = 1'b1; bus_a.I_lane_en = 4'hF;
        @(negedge clk); bus_a.I_restart = 1'b0;
        e0 = x + 1;
        seq_exp(0, e0, 4'hF, 8'd0, e0 + A_SP + A_RP + 3, tr);
        pe(0, e0 + A_SP + A_RP + 3, BIG, ST_IDLE, 1'b0, 4'h0, 1'b0, 8'd1);
        wait_until(e0 + A_SP + A_RP + 2);
        bus_a.I_pll_lock = 1'b0;
        @(negedge clk);
        check("A_loss_lanes",    32'(bus_a.O_serdes_rst),    32'h0);
        check("A_loss_clk_stop", 32'(bus_a.O_clk_stop),      32'd0);
        check("A_loss_state",    32'(bus_a.O_state),         32'd0);
        check("A_loss_count",    32'(bus_a.O_lock_lost_cnt), 32'd1);

        // Relock with a one-cycle glitch 40 cycles into LOCK_WAIT: debounce restarts.
        repeat (3) @(negedge clk);
        x = cyc; bus_a.I_pll_lock = 1'b1;
        pe(0, x + 1, BIG, ST_LOCK_WAIT, 1'b0, 4'h0, 1'b0, 8'd1);
        wait_until(x + 40);
        bus_a.I_pll_lock = 1'b0;
        @(negedge clk);
        x = cyc; bus_a.I_pll_lock = 1'b1;
        e0 = x + A_TL + 1;
        seq_exp(0, e0, 4'hF, 8'd1, BIG, tr);
        wait_until(e0 + A_SP - 1);
        check("A_glitch_no_stop", 32'(bus_a.O_clk_stop), 32'd0);
        wait_until(tr + 2);
        check("A_relock_ready", 32'(bus_a.O_ready), 32'd1);

        // Lane gap 3 with mask 1011.
        x = cyc; bus_b.I_lane_en = 4'b1011; bus_b.I_pll_lock = 1'b1;
        pe(1, x + 1, BIG, ST_LOCK_WAIT, 1'b0, 4'h0, 1'b0, 8'd0);
        e0 = x + B_TL + 1;
        seq_exp(1, e0, 4'b1011, 8'd0, BIG, tr);
        wait_until(e0 + B_SP + B_RP + 1);
        check("B_rst_mask", 32'(bus_b.O_serdes_rst), 32'hB);
        wait_until(tr + 2);

        // 300 lock losses: first in READY, then 299 inside STOP_S.
        lcb = 8'd1;
        x = cyc; bus_b.I_pll_lock = 1'b0;
        pe(1, x + 1, BIG, ST_IDLE, 1'b0, 4'h0, 1'b0, lcb);
        @(negedge clk);
        for (int i = 0; i < 299; i++) begin
            x = cyc; bus_b.I_pll_lock = 1'b1;
            pe(1, x + 1, BIG, ST_LOCK_WAIT, 1'b0, 4'h0, 1'b0, lcb);
            pe(1, x + B_TL + 1, BIG, ST_STOP_S, 1'b0, 4'h0, 1'b0, lcb);
            wait_until(x + B_TL + 1);
            bus_b.I_pll_lock = 1'b0;
            lcb = (lcb == 8'hFF) ? 8'hFF : lcb + 8'd1;
            pe(1, x + B_TL + 2, BIG, ST_IDLE, 1'b0, 4'h0, 1'b0, lcb);
            @(negedge clk);
        end
        check("B_lost_saturated", 32'(bus_b.O_lock_lost_cnt), 32'd255);

        // Asynchronous reset in the middle of STOP_E.
        x = cyc; bus_b.I_pll_lock = 1'b1;
        pe(1, x + 1, BIG, ST_LOCK_WAIT, 1'b0, 4'h0, 1'b0, 8'd255);
        e0 = x + B_TL + 1;
        seq_exp(1, e0, 4'b1011, 8'd255, e0 + 17, tr);
        pe(1, e0 + 17, BIG, ST_IDLE, 1'b0, 4'h0, 1'b0, 8'd0);
        wait_until(e0 + 16);
        #2 rst_b = 1'b1;
        #1;
        check("B_arst_clk_stop", 32'(bus_b.O_clk_stop),      32'd0);
        check("B_arst_lanes",    32'(bus_b.O_serdes_rst),    32'h0);
        check("B_arst_state",    32'(bus_b.O_state),         32'd0);
        check("B_arst_lost",     32'(bus_b.O_lock_lost_cnt), 32'd0);
        check("B_arst_ready",    32'(bus_b.O_ready),         32'd0);
        bus_b.I_pll_lock = 1'b0;
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        repeat (5) @(negedge clk);

        check("A_scoreboard_empty", 32'(qa.size()), 32'd0);
        check("B_scoreboard_empty", 32'(qb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
